// File: rtl/tlb_l2_arbiter.sv
// Round-robin arbiter sharing one L2 TLB search engine between the inst and data miss paths.
// TLB maintenance is serialized against lookups; lookups it overlaps come back flagged for retry.
module tlb_l2_arbiter #(
    parameter int IDX_W  = 4,
    parameter int L2_LAT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req_valid,
    output logic             i_req_ready,
    input  logic [18:0]      i_req_vppn,
    input  logic [9:0]       i_req_asid,
    output logic             i_resp_valid,
    output logic             i_resp_found,
    output logic [IDX_W-1:0] i_resp_index,
    output logic             i_resp_retry,
    input  logic             d_req_valid,
    output logic             d_req_ready,
    input  logic [18:0]      d_req_vppn,
    input  logic [9:0]       d_req_asid,
    output logic             d_resp_valid,
    output logic             d_resp_found,
    output logic [IDX_W-1:0] d_resp_index,
    output logic             d_resp_retry,
    output logic             l2_valid,
    output logic [18:0]      l2_vppn,
    output logic [9:0]       l2_asid,
    input  logic             l2_found,
    input  logic [IDX_W-1:0] l2_index,
    input  logic             maint_req,
    output logic             maint_ack,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, LOOKUP, RESP, MAINT} state_t;

    state_t                 state;
    logic [1:0]             cnt;
    logic                   stale;
    logic                   last_grant;  // 0 = inst, 1 = data
    logic                   owner;
    logic [1:0]             resp_valid, resp_found, resp_retry;
    logic [1:0][IDX_W-1:0]  resp_index;
    logic                   win_i, win_d, hs_i, hs_d, stale_now;

    // A lone requester always wins; under contention the side not served last wins.
    assign win_i = i_req_valid & (~d_req_valid | last_grant);
    assign win_d = d_req_valid & (~i_req_valid | ~last_grant);
    assign i_req_ready = (state == IDLE) & ~maint_req & win_i;
    assign d_req_ready = (state == IDLE) & ~maint_req & win_d;
    assign hs_i = i_req_valid & i_req_ready;
    assign hs_d = d_req_valid & d_req_ready;
    assign stale_now = stale | maint_req;

    assign i_resp_valid = resp_valid[0];
    assign i_resp_found = resp_found[0];
    assign i_resp_index = resp_index[0];
    assign i_resp_retry = resp_retry[0];
    assign d_resp_valid = resp_valid[1];
    assign d_resp_found = resp_found[1];
    assign d_resp_index = resp_index[1];
    assign d_resp_retry = resp_retry[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            stale      <= 1'b0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            resp_valid <= '0;
            resp_found <= '0;
            resp_retry <= '0;
            resp_index <= '0;
            l2_valid   <= 1'b0;
            l2_vppn    <= '0;
            l2_asid    <= '0;
            maint_ack  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (maint_req) begin
                        state     <= MAINT;
                        maint_ack <= 1'b1;
                        busy      <= 1'b1;
                    end else if (hs_i | hs_d) begin
                        l2_vppn    <= hs_d ? d_req_vppn : i_req_vppn;
                        l2_asid    <= hs_d ? d_req_asid : i_req_asid;
                        owner      <= hs_d;
                        last_grant <= hs_d;
                        cnt        <= 2'(L2_LAT);
                        l2_valid   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (maint_req)
                        stale <= 1'b1;
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else begin
                        // Search still runs to completion; a stale result is masked to a retry.
                        resp_valid[owner] <= 1'b1;
                        resp_found[owner] <= l2_found & ~stale_now;
                        resp_index[owner] <= stale_now ? '0 : l2_index;
                        resp_retry[owner] <= stale_now;
                        l2_valid          <= 1'b0;
                        state             <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= '0;
                    stale      <= 1'b0;
                    if (maint_req) begin
                        state     <= MAINT;
                        maint_ack <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                MAINT: begin
                    maint_ack <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tlb_l2_arbiter.sv
// Directed bench for tlb_l2_arbiter: one instance per L2_LAT (0..3) on shared stimulus,
// a table of single lookups plus hand-written contention, maintenance and reset sequences.
module tb_tlb_l2_arbiter;
    localparam int IDX_W = 4;
    localparam int NDUT  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic i_req_valid = 1'b0, d_req_valid = 1'b0;
    logic [18:0] i_req_vppn = '0, d_req_vppn = '0;
    logic [9:0] i_req_asid = '0, d_req_asid = '0;
    logic l2_found = 1'b0;
    logic [IDX_W-1:0] l2_index = '0;
    logic maint_req = 1'b0;

    logic i_req_ready [NDUT];
    logic d_req_ready [NDUT];
    logic i_resp_valid [NDUT];
    logic i_resp_found [NDUT];
    logic [IDX_W-1:0] i_resp_index [NDUT];
    logic i_resp_retry [NDUT];
    logic d_resp_valid [NDUT];
    logic d_resp_found [NDUT];
    logic [IDX_W-1:0] d_resp_index [NDUT];
    logic d_resp_retry [NDUT];
    logic l2_valid [NDUT];
    logic [18:0] l2_vppn [NDUT];
    logic [9:0] l2_asid [NDUT];
    logic maint_ack [NDUT];
    logic busy [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        tlb_l2_arbiter #(.IDX_W(IDX_W), .L2_LAT(g)) u_dut (
            .clk(clk), .reset(reset),
            .i_req_valid(i_req_valid), .i_req_ready(i_req_ready[g]),
            .i_req_vppn(i_req_vppn), .i_req_asid(i_req_asid),
            .i_resp_valid(i_resp_valid[g]), .i_resp_found(i_resp_found[g]),
            .i_resp_index(i_resp_index[g]), .i_resp_retry(i_resp_retry[g]),
            .d_req_valid(d_req_valid), .d_req_ready(d_req_ready[g]),
            .d_req_vppn(d_req_vppn), .d_req_asid(d_req_asid),
            .d_resp_valid(d_resp_valid[g]), .d_resp_found(d_resp_found[g]),
            .d_resp_index(d_resp_index[g]), .d_resp_retry(d_resp_retry[g]),
            .l2_valid(l2_valid[g]), .l2_vppn(l2_vppn[g]), .l2_asid(l2_asid[g]),
            .l2_found(l2_found), .l2_index(l2_index),
            .maint_req(maint_req), .maint_ack(maint_ack[g]), .busy(busy[g])
        );
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Leaves the bench just after a negedge with reset released and all inputs idle.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        maint_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        int          lat;
        bit          side;      // 0 inst, 1 data
        logic [18:0] vppn;
        logic [9:0]  asid;
        bit          found;
        logic [3:0]  index;
        int          maint_at;  // LOOKUP cycle (0 = first) where maint_req rises, -1 none
        bit          exp_found;
        logic [3:0]  exp_index;
        bit          exp_retry;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{0, 1'b0, 19'h12345, 10'h003, 1'b1, 4'h5, -1, 1'b1, 4'h5, 1'b0};
        vecs[1] = '{3, 1'b0, 19'h0abcd, 10'h155, 1'b0, 4'h9, -1, 1'b0, 4'h9, 1'b0};
        vecs[2] = '{3, 1'b1, 19'h7ffff, 10'h3ff, 1'b0, 4'h9, -1, 1'b0, 4'h9, 1'b0};
        vecs[3] = '{2, 1'b1, 19'h00042, 10'h001, 1'b1, 4'ha,  0, 1'b0, 4'h0, 1'b1};
        vecs[4] = '{1, 1'b1, 19'h54321, 10'h2aa, 1'b1, 4'hf, -1, 1'b1, 4'hf, 1'b0};
        vecs[5] = '{3, 1'b0, 19'h11111, 10'h007, 1'b1, 4'h3,  3, 1'b0, 4'h0, 1'b1};
        vecs[6] = '{2, 1'b0, 19'h22222, 10'h008, 1'b1, 4'hc,  1, 1'b0, 4'h0, 1'b1};

        // Reset state
        apply_reset();
        #1;
        for (int s = 0; s < NDUT; s++) begin
            chk("rst_l2_valid", 32'(l2_valid[s]), 0);
            chk("rst_busy", 32'(busy[s]), 0);
            chk("rst_maint_ack", 32'(maint_ack[s]), 0);
            chk("rst_resp_valid", 32'({i_resp_valid[s], d_resp_valid[s]}), 0);
            chk("rst_l2_vppn", 32'(l2_vppn[s]), 0);
        end

        // Table of single lookups
        for (int v = 0; v < 7; v++) begin
            int  s;
            bit  m;
            s = vecs[v].lat;
            m = 1'b0;
            apply_reset();
            l2_found = vecs[v].found;
            l2_index = vecs[v].index;
            if (vecs[v].side) begin
                d_req_valid = 1'b1; d_req_vppn = vecs[v].vppn; d_req_asid = vecs[v].asid;
            end else begin
                i_req_valid = 1'b1; i_req_vppn = vecs[v].vppn; i_req_asid = vecs[v].asid;
            end
            #1;
            chk("t_i_ready", 32'(i_req_ready[s]), 32'(!vecs[v].side));
            chk("t_d_ready", 32'(d_req_ready[s]), 32'(vecs[v].side));
            @(negedge clk);
            i_req_valid = 1'b0;
            d_req_valid = 1'b0;
            for (int j = 0; j <= vecs[v].lat; j++) begin
                if (j == vecs[v].maint_at) begin
                    maint_req = 1'b1;
                    m = 1'b1;
                end
                #1;
                chk("t_l2_valid", 32'(l2_valid[s]), 1);
                chk("t_l2_vppn", 32'(l2_vppn[s]), 32'(vecs[v].vppn));
                chk("t_l2_asid", 32'(l2_asid[s]), 32'(vecs[v].asid));
                chk("t_early_resp", 32'({i_resp_valid[s], d_resp_valid[s]}), 0);
                @(negedge clk);
            end
            #1;
            chk("t_l2_valid_off", 32'(l2_valid[s]), 0);
            chk("t_resp_valid", 32'({d_resp_valid[s], i_resp_valid[s]}),
                vecs[v].side ? 32'h2 : 32'h1);
            chk("t_resp_found", 32'(vecs[v].side ? d_resp_found[s] : i_resp_found[s]),
                32'(vecs[v].exp_found));
            chk("t_resp_index", 32'(vecs[v].side ? d_resp_index[s] : i_resp_index[s]),
                32'(vecs[v].exp_index));
            chk("t_resp_retry", 32'(vecs[v].side ? d_resp_retry[s] : i_resp_retry[s]),
                32'(vecs[v].exp_retry));
            @(negedge clk);
            #1;
            chk("t_resp_pulse", 32'({i_resp_valid[s], d_resp_valid[s]}), 0);
            chk("t_maint_ack", 32'(maint_ack[s]), 32'(m));
            chk("t_busy_after", 32'(busy[s]), 32'(m));
            maint_req = 1'b0;
        end

        // Continuous contention, L2_LAT=1: inst at 0, data at 4, ... responses 3 cycles later
        apply_reset();
        l2_found = 1'b1;
        l2_index = 4'h6;
        i_req_valid = 1'b1; i_req_vppn = 19'h00100;
        d_req_valid = 1'b1; d_req_vppn = 19'h00200;
        for (int c = 0; c < 17; c++) begin
            #1;
            chk("rr_i_ready", 32'(i_req_ready[1]), 32'(c % 8 == 0));
            chk("rr_d_ready", 32'(d_req_ready[1]), 32'(c % 8 == 4));
            chk("rr_i_resp", 32'(i_resp_valid[1]), 32'(c % 8 == 3));
            chk("rr_d_resp", 32'(d_resp_valid[1]), 32'(c % 8 == 7));
            if (c % 8 == 3) chk("rr_i_index", 32'(i_resp_index[1]), 32'h6);
            if (c % 8 == 7) chk("rr_d_index", 32'(d_resp_index[1]), 32'h6);
            @(negedge clk);
        end

        // maint_req and a request together in IDLE: maintenance wins, re-enters while held
        apply_reset();
        maint_req = 1'b1;
        i_req_valid = 1'b1;
        #1;
        chk("mi_ready0", 32'(i_req_ready[0]), 0);
        @(negedge clk); #1;
        chk("mi_ack1", 32'(maint_ack[0]), 1);
        chk("mi_busy1", 32'(busy[0]), 1);
        chk("mi_ready1", 32'(i_req_ready[0]), 0);
        @(negedge clk); #1;
        chk("mi_ack2", 32'(maint_ack[0]), 0);
        chk("mi_ready2", 32'(i_req_ready[0]), 0);
        @(negedge clk); #1;
        chk("mi_ack3", 32'(maint_ack[0]), 1);
        maint_req = 1'b0;
        @(negedge clk); #1;
        chk("mi_ready_after", 32'(i_req_ready[0]), 1);
        chk("mi_d_ready_after", 32'(d_req_ready[0]), 0);
        i_req_valid = 1'b0;

        // Reset mid-LOOKUP (L2_LAT=2): everything drops, no response, first tie grants inst
        apply_reset();
        d_req_valid = 1'b1;
        d_req_vppn = 19'h0beef;
        @(negedge clk);
        d_req_valid = 1'b0;
        #1;
        chk("rl_l2_valid", 32'(l2_valid[2]), 1);
        chk("rl_busy", 32'(busy[2]), 1);
        reset = 1'b1;
        #1;
        chk("rl_l2_valid_drop", 32'(l2_valid[2]), 0);
        chk("rl_busy_drop", 32'(busy[2]), 0);
        chk("rl_l2_vppn_drop", 32'(l2_vppn[2]), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("rl_no_resp", 32'({i_resp_valid[2], d_resp_valid[2]}), 0);
            @(negedge clk);
        end
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        #1;
        chk("rl_tie_i", 32'(i_req_ready[2]), 1);
        chk("rl_tie_d", 32'(d_req_ready[2]), 0);
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
